// File: rtl/alu_pkg.sv
// Shared opcode encodings and default datapath width for the LEGv8 execute-stage ALU.
package alu_pkg;

  localparam int unsigned ALU_W = 64;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111
  } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// N-bit adder/subtractor shared by ADD and SUB: sub=1 computes a + ~b + 1.
module alu_addsub #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  logic [N-1:0] w_b_eff;
  logic [N:0]   w_full;

  always_comb begin
    w_b_eff = sub ? ~b : b;
    w_full  = {1'b0, a} + {1'b0, w_b_eff} + {{N{1'b0}}, sub};
    sum     = w_full[N-1:0];
    cout    = w_full[N];
    // Operands of the effective addition share a sign that the sum does not.
    ovf     = (a[N-1] == w_b_eff[N-1]) && (w_full[N-1] != a[N-1]);
  end

endmodule

// File: rtl/alu_core.sv
// 64-bit LEGv8 ALU: opcode mux, zero detect and one output register stage.
// Define ALU_FLAGS_EN to add registered negative/carry/overflow outputs.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned N = ALU_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
`ifdef ALU_FLAGS_EN
  output logic         negative,
  output logic         carry,
  output logic         overflow,
`endif
  output logic [N-1:0] result,
  output logic         zero
);

  logic [N-1:0] w_sum;
  logic         w_cout;
  logic         w_ovf;
  logic         w_sub;
  logic         w_arith;
  logic [N-1:0] w_next;

  assign w_sub   = (ALUControl == ALU_SUB);
  assign w_arith = (ALUControl == ALU_ADD) || w_sub;

  alu_addsub #(
    .N (N)
  ) u_addsub (
    .a    (a),
    .b    (b),
    .sub  (w_sub),
    .sum  (w_sum),
    .cout (w_cout),
    .ovf  (w_ovf)
  );

  always_comb begin
    w_next = '0;
    case (ALUControl)
      ALU_AND:   w_next = a & b;
      ALU_OR:    w_next = a | b;
      ALU_ADD:   w_next = w_sum;
      ALU_SUB:   w_next = w_sum;
      ALU_PASSB: w_next = b;
      default:   w_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      zero   <= 1'b1;
    end else begin
      result <= w_next;
      zero   <= (w_next == '0);
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      negative <= w_next[N-1];
      carry    <= w_arith & w_cout;
      overflow <= w_arith & w_ovf;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_arith ^ w_cout ^ w_ovf;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core; flag checks are compiled in with ALU_FLAGS_EN.
module tb_alu_core;

  logic        clk;
  logic        reset;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  ALUControl;
  logic [63:0] result;
  logic        zero;
`ifdef ALU_FLAGS_EN
  logic        negative;
  logic        carry;
  logic        overflow;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  alu_core #(.N(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
`ifdef ALU_FLAGS_EN
    .negative   (negative),
    .carry      (carry),
    .overflow   (overflow),
`endif
    .result     (result),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string tag, input logic [3:0] op, input logic [63:0] va,
                         input logic [63:0] vb, input logic [63:0] res, input logic z,
                         input logic n, input logic c, input logic v);
    vec_t t;
    t.tag = tag; t.op = op; t.a = va; t.b = vb; t.res = res;
    t.z = z; t.n = n; t.c = c; t.v = v;
    vecs.push_back(t);
  endtask

  task automatic check_flags(input string tag, input logic n, input logic c, input logic v);
`ifdef ALU_FLAGS_EN
    check({tag, "_neg"}, {63'd0, negative}, {63'd0, n});
    check({tag, "_carry"}, {63'd0, carry}, {63'd0, c});
    check({tag, "_ovf"}, {63'd0, overflow}, {63'd0, v});
`else
    if (n === 1'bx || c === 1'bx || v === 1'bx) $display("note: %s flag vector incomplete", tag);
`endif
  endtask

  initial begin
    reset = 1'b1; a = '0; b = '0; ALUControl = 4'b0000;

    //        tag        op       a                      b                      result                 z     n     c     v
    add_vec("and",     4'b0000, 64'h1555555555555555, 64'h1999999999999999, 64'h1111111111111111, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("or",      4'b0001, 64'h1555555555555555, 64'h1999999999999999, 64'h1DDDDDDDDDDDDDDD, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("add_pos", 4'b0010, 64'd10,               64'd11,               64'd21,               1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("add_neg", 4'b0010, 64'hFFFFFFFFFFFFFFF6, 64'hFFFFFFFFFFFFFFFB, 64'hFFFFFFFFFFFFFFF1, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec("add_mix", 4'b0010, 64'hFFFFFFFFFFFFFFF6, 64'd11,               64'd1,                1'b0, 1'b0, 1'b1, 1'b0);
    add_vec("sub_pos", 4'b0110, 64'd12,               64'd10,               64'd2,                1'b0, 1'b0, 1'b1, 1'b0);
    add_vec("sub_nn",  4'b0110, 64'hFFFFFFFFFFFFFFF4, 64'hFFFFFFFFFFFFFFF6, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec("sub_np",  4'b0110, 64'hFFFFFFFFFFFFFFF4, 64'd10,               64'hFFFFFFFFFFFFFFEA, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec("passb",   4'b0111, 64'hDEAD,             64'd10,               64'd10,               1'b0, 1'b0, 1'b0, 1'b0);
    add_vec("add_wrap",4'b0010, 64'hFFFFFFFFFFFFFFFF, 64'd1,                64'd0,                1'b1, 1'b0, 1'b1, 1'b0);
    add_vec("and_zero",4'b0000, 64'd0,                64'd0,                64'd0,                1'b1, 1'b0, 1'b0, 1'b0);
    add_vec("bad_op",  4'b1111, 64'h1234,             64'h5678,             64'd0,                1'b1, 1'b0, 1'b0, 1'b0);
    add_vec("sub_eq",  4'b0110, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'd0,                1'b1, 1'b0, 1'b1, 1'b0);
    add_vec("add_ovf", 4'b0010, 64'h7FFFFFFFFFFFFFFF, 64'd1,                64'h8000000000000000, 1'b0, 1'b1, 1'b0, 1'b1);
    add_vec("sub_ovf", 4'b0110, 64'h8000000000000000, 64'd1,                64'h7FFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    add_vec("bad_op3", 4'b0011, 64'hFFFF,             64'hFFFF,             64'd0,                1'b1, 1'b0, 1'b0, 1'b0);

    @(posedge clk); #1;
    check("reset_result", result, 64'd0);
    check("reset_zero", {63'd0, zero}, 64'd1);
    check_flags("reset", 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = 1'b0; a = vecs[i].a; b = vecs[i].b; ALUControl = vecs[i].op;
      @(posedge clk); #1;
      check({vecs[i].tag, "_result"}, result, vecs[i].res);
      check({vecs[i].tag, "_zero"}, {63'd0, zero}, {63'd0, vecs[i].z});
      check_flags(vecs[i].tag, vecs[i].n, vecs[i].c, vecs[i].v);
    end

    // Reset must override a live ADD that would otherwise produce a nonzero, flagged result.
    @(negedge clk);
    a = 64'hFFFFFFFFFFFFFFF6; b = 64'hFFFFFFFFFFFFFFFB; ALUControl = 4'b0010;
    @(posedge clk); #1;
    check("pre_rst_result", result, 64'hFFFFFFFFFFFFFFF1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_prio_result", result, 64'd0);
    check("rst_prio_zero", {63'd0, zero}, 64'd1);
    check_flags("rst_prio", 1'b0, 1'b0, 1'b0);

    // Output holds between edges: change inputs mid-cycle and confirm no combinational path.
    @(negedge clk);
    reset = 1'b0; a = 64'd5; b = 64'd7; ALUControl = 4'b0010;
    @(posedge clk); #1;
    a = 64'd100;
    #2;
    check("hold_result", result, 64'd12);
    check("hold_zero", {63'd0, zero}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
